// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: region encodings and 640x480@60 defaults.
// Imported by the sync generator and by renderers.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        R_ACTIVE = 2'd0,
        R_FRONT  = 2'd1,
        R_SYNC   = 2'd2,
        R_BACK   = 2'd3
    } region_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter, region FSM and registered sync decode.
// Used for both the horizontal (pixel) and vertical (line) axis.
import vga_timing_pkg::*;

module vga_axis_counter #(
    parameter int CNT_W = 10,
    parameter int ACT   = 640,
    parameter int FP    = 16,
    parameter int SYN   = 96,
    parameter int BP    = 48,
    parameter bit POL   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_out,
    output logic             active_n
);

    localparam int TOTAL  = ACT + FP + SYN + BP;
    localparam int LAST_I = TOTAL - 1;
    localparam int E_FP_I = ACT + FP;
    localparam int E_SY_I = ACT + FP + SYN;

    localparam logic [CNT_W-1:0] LAST  = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W:0]   E_ACT = ACT[CNT_W:0];
    localparam logic [CNT_W:0]   E_FP  = E_FP_I[CNT_W:0];
    localparam logic [CNT_W:0]   E_SYN = E_SY_I[CNT_W:0];

    region_t          state;
    region_t          state_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W:0]   cnt_ext;

    always_comb begin
        wrap    = advance && (count == LAST);
        count_n = count;
        if (advance) begin
            count_n = wrap ? '0 : count + 1'b1;
        end
        cnt_ext = {1'b0, count_n};
        state_n = state;
        // Empty porches are skipped by jumping past them.
        if (advance) begin
            case (state)
                R_ACTIVE: if (cnt_ext == E_ACT)
                    state_n = (FP == 0) ? R_SYNC : R_FRONT;
                R_FRONT:  if (cnt_ext == E_FP)
                    state_n = R_SYNC;
                R_SYNC: begin
                    if (wrap)
                        state_n = R_ACTIVE;
                    else if (cnt_ext == E_SYN)
                        state_n = R_BACK;
                end
                R_BACK:   if (wrap)
                    state_n = R_ACTIVE;
                default:  state_n = R_ACTIVE;
            endcase
        end
        active_n = (state_n == R_ACTIVE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            state    <= R_ACTIVE;
            sync_out <= ~POL;
        end else begin
            count    <= count_n;
            state    <= state_n;
            sync_out <= (state_n == R_SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator with pixel divider and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_count output.
import vga_timing_pkg::*;

module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int CNT_W      = 10,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_done,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic             frame_done,
    output logic [15:0]      frame_count
`else
    output logic             frame_done
`endif
);

    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DIV_LAST_I = CLK_DIV - 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_LAST_I[DIV_W-1:0];

    logic [DIV_W-1:0] div;
    logic             h_act_n;
    logic             v_act_n;

    assign pixel_tick = enable && (div == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            div <= '0;
        end else if (enable) begin
            div <= pixel_tick ? '0 : div + 1'b1;
        end
    end

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACT   (H_ACTIVE),
        .FP    (H_FP),
        .SYN   (H_SYNC),
        .BP    (H_BP),
        .POL   (H_SYNC_POL)
    ) u_h (
        .clock    (clock),
        .reset    (reset),
        .advance  (pixel_tick),
        .count    (pixel_x),
        .wrap     (line_done),
        .sync_out (hsync),
        .active_n (h_act_n)
    );

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .ACT   (V_ACTIVE),
        .FP    (V_FP),
        .SYN   (V_SYNC),
        .BP    (V_BP),
        .POL   (V_SYNC_POL)
    ) u_v (
        .clock    (clock),
        .reset    (reset),
        .advance  (line_done),
        .count    (pixel_y),
        .wrap     (frame_done),
        .sync_out (vsync),
        .active_n (v_act_n)
    );

    // Loaded from next-state decode so it lines up with the coordinates.
    always_ff @(posedge clock) begin
        if (reset) begin
            video_on <= 1'b1;
        end else begin
            video_on <= h_act_n && v_act_n;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_done) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode, a small 14x7 mode with high-true syncs,
// and a 12x7 mode with a zero-length horizontal front porch.
module tb_vga_timing_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, en_a, en_b, en_c;

    logic       a_tick, a_hs, a_vs, a_von, a_ld, a_fd;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_von, b_ld, b_fd;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_hs, c_vs, c_von, c_ld, c_fd;
    logic [9:0] c_x, c_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc, c_fc;
`endif

    int tests  = 0;
    int failed = 0;

    vga_timing_gen dut_a (
        .clock(clock), .reset(reset), .enable(en_a),
        .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
        .line_done(a_ld),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_done(a_fd), .frame_count(a_fc)
`else
        .frame_done(a_fd)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .CNT_W(10),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(en_b),
        .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
        .line_done(b_ld),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_done(b_fd), .frame_count(b_fc)
`else
        .frame_done(b_fd)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .CNT_W(10),
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut_c (
        .clock(clock), .reset(reset), .enable(en_c),
        .pixel_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_von),
        .line_done(c_ld),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_done(c_fd), .frame_count(c_fc)
`else
        .frame_done(c_fd)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int ax, ay, bx, by, cx, cy;
        int b_prev;
        int von_cnt;
        bit found;

        reset = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        en_c  = 1'b1;
        step(2);

        check("rst_a_x",   32'(a_x),   0);
        check("rst_a_y",   32'(a_y),   0);
        check("rst_a_hs",  32'(a_hs),  1);
        check("rst_a_vs",  32'(a_vs),  1);
        check("rst_a_von", 32'(a_von), 1);
        check("rst_a_tick",32'(a_tick),0);
        check("rst_a_ld",  32'(a_ld),  0);
        check("rst_a_fd",  32'(a_fd),  0);
        check("rst_b_hs",  32'(b_hs),  0);
        check("rst_b_vs",  32'(b_vs),  0);
        check("rst_b_von", 32'(b_von), 1);
        check("rst_b_fd",  32'(b_fd),  0);

        reset   = 1'b0;
        b_prev  = -1;
        von_cnt = 0;

        for (int c = 0; c <= 4402; c++) begin
            ax = (c / 4) % 800;
            ay = ((c / 4) / 800) % 525;
            check("a_x",    32'(a_x),    ax);
            check("a_y",    32'(a_y),    ay);
            check("a_tick", 32'(a_tick), 32'(c % 4 == 3));
            check("a_ld",   32'(a_ld),
                  32'(c % 4 == 3 && ax == 799));
            check("a_hs",   32'(a_hs),
                  32'(!(ax >= 656 && ax < 752)));
            check("a_von",  32'(a_von),
                  32'(ax < 640 && ay < 480));

            bx = c % 14;
            by = (c / 14) % 7;
            check("b_x",   32'(b_x),   bx);
            check("b_y",   32'(b_y),   by);
            check("b_hs",  32'(b_hs),  32'(bx >= 10 && bx < 12));
            check("b_vs",  32'(b_vs),  32'(by == 5));
            check("b_von", 32'(b_von), 32'(bx < 8 && by < 4));
            check("b_ld",  32'(b_ld),  32'(bx == 13));
            check("b_fd",  32'(b_fd),  32'(bx == 13 && by == 6));
            check("b_hreg", 32'(dut_b.u_h.state),
                  (bx < 8) ? 0 : (bx < 10) ? 1 : (bx < 12) ? 2 : 3);
            if (c < 98) von_cnt += int'(b_von);
            if (c == 97) check("b_von_per_frame", von_cnt, 32);
            if (b_fd) begin
                if (b_prev >= 0)
                    check("b_frame_period", c - b_prev, 98);
                b_prev = c;
            end

            cx = c % 12;
            cy = (c / 12) % 7;
            check("c_x",   32'(c_x),   cx);
            check("c_hs",  32'(c_hs),  32'(!(cx >= 8 && cx < 10)));
            check("c_fd",  32'(c_fd),  32'(cx == 11 && cy == 6));
            check("c_hreg", 32'(dut_c.u_h.state),
                  (cx < 8) ? 0 : (cx < 10) ? 2 : 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("c_fcount", 32'(c_fc), c / 84);
            if (c == 252) check("c_fcount_3", 32'(c_fc), 3);
`endif
            step(1);
        end

        // dut_a now sits at x=300, y=1 with its divider at terminal count.
        en_a = 1'b0;
        #1;
        check("hold_tick0", 32'(a_tick), 0);
        check("hold_ld0",   32'(a_ld),   0);
        repeat (50) begin
            step(1);
            check("hold_x",    32'(a_x),    300);
            check("hold_y",    32'(a_y),    1);
            check("hold_hs",   32'(a_hs),   1);
            check("hold_von",  32'(a_von),  1);
            check("hold_tick", 32'(a_tick), 0);
        end
        en_a = 1'b1;
        #1;
        check("resume_tick", 32'(a_tick), 1);
        check("resume_x",    32'(a_x),    300);
        step(1);
        check("resume_x301", 32'(a_x),    301);
        check("resume_t0",   32'(a_tick), 0);
        step(2);
        check("resume_t2",   32'(a_tick), 0);
        step(1);
        check("resume_t3",   32'(a_tick), 1);
        check("resume_x301b",32'(a_x),    301);
        step(1);
        check("resume_x302", 32'(a_x),    302);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (b_x == 10'd11 && b_y == 10'd5) found = 1'b1;
            else step(1);
        end
        check("b_reach_sync", 32'(found), 1);
        check("pre_rst_b_hs", 32'(b_hs), 1);
        check("pre_rst_b_vs", 32'(b_vs), 1);

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        #1;
        check("mid_rst_b_x",   32'(b_x),   0);
        check("mid_rst_b_y",   32'(b_y),   0);
        check("mid_rst_b_hs",  32'(b_hs),  0);
        check("mid_rst_b_vs",  32'(b_vs),  0);
        check("mid_rst_b_von", 32'(b_von), 1);
        check("mid_rst_b_ld",  32'(b_ld),  0);
        check("mid_rst_b_fd",  32'(b_fd),  0);
        check("mid_rst_a_x",   32'(a_x),   0);
        check("mid_rst_a_y",   32'(a_y),   0);
        check("mid_rst_a_hs",  32'(a_hs),  1);
        check("mid_rst_a_von", 32'(a_von), 1);
        check("mid_rst_a_ld",  32'(a_ld),  0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("mid_rst_c_fc",  32'(c_fc),  0);
`endif
        step(1);
        check("restart_b_x",   32'(b_x),   1);
        check("restart_a_x",   32'(a_x),   0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
